// File: rtl/fetch_response_queue_pkg.sv
// Shared types and sizing helpers for the fetch response queue.
package fetch_response_queue_pkg;

  localparam int FQ_XLEN = 32;

  // One decoded-side entry: the PC that was issued and the word that came back.
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fetch_entry_t;

  // Queue pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_response_queue_ptrs.sv
// Alloc/fill/read circular pointers and the occupancy counts derived from them.
module fetch_queue_ptrs
  import fetch_response_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = fq_ptr_w(DEPTH),
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alloc_inc,
  input  logic          fill_inc,
  input  logic          read_inc,
  output logic [IW-1:0] alloc_idx,
  output logic [IW-1:0] fill_idx,
  output logic [IW-1:0] read_idx,
  output logic [PW-1:0] pending,
  output logic [PW-1:0] ready_cnt,
  output logic [PW-1:0] used
);

  logic [PW-1:0] alloc_ptr, fill_ptr, read_ptr;

  // Pointers advance independently; flush returns all three to the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
    end else begin
      if (alloc_inc) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_inc)  fill_ptr  <= fill_ptr  + PW'(1);
      if (read_inc)  read_ptr  <= read_ptr  + PW'(1);
    end
  end

  // Modulo differences: the wrap bit makes a full queue read as DEPTH, not 0.
  assign pending   = alloc_ptr - fill_ptr;
  assign ready_cnt = fill_ptr  - read_ptr;
  assign used      = alloc_ptr - read_ptr;

  assign alloc_idx = alloc_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign read_idx  = read_ptr[IW-1:0];

endmodule

// File: rtl/fetch_response_queue.sv
// Pairs each issued fetch PC with its in-order cache response and hands the
// {pc, instr} pair to decode. Flush drops queued entries and swallows any
// responses still owed by the cache for flushed requests.
module fetch_response_queue
  import fetch_response_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_issue,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_instr,
  input  logic        flush,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  input  logic        dec_pop
);

  localparam int PW = fq_ptr_w(DEPTH);
  localparam int IW = $clog2(DEPTH);
  localparam int DW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW = PW + DW;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_response_queue: DEPTH must be a power of 2 and >= 2");
  end

  logic [IW-1:0] alloc_idx, fill_idx, read_idx;
  logic [PW-1:0] pending, ready_cnt, used;
  logic [DW-1:0] drop_count;
  logic [CW-1:0] inflight;
  logic          room_ok;
  logic          alloc_inc, rsp_store, rsp_drop, pop_ok;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  fetch_entry_t  head;

  // Everything the cache still owes us, live or to be discarded.
  assign inflight  = CW'(pending) + CW'(drop_count);
  assign room_ok   = (used < PW'(DEPTH)) && (inflight < CW'(MAX_OUTSTANDING));
  assign req_ready = ~flush & room_ok;

  // Owed drops are paid off before any response is treated as live.
  assign rsp_drop  = rsp_valid & (drop_count != '0);
  assign rsp_store = rsp_valid & (drop_count == '0) & ~flush;
  assign alloc_inc = req_issue & ~flush;
  assign dec_valid = (ready_cnt != '0);
  assign pop_ok    = dec_pop & dec_valid & ~flush;

  fetch_queue_ptrs #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .IW    (IW)
  ) u_ptrs (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .alloc_inc (alloc_inc),
    .fill_inc  (rsp_store),
    .read_inc  (pop_ok),
    .alloc_idx (alloc_idx),
    .fill_idx  (fill_idx),
    .read_idx  (read_idx),
    .pending   (pending),
    .ready_cnt (ready_cnt),
    .used      (used)
  );

  // Record the PC of each request at allocation time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pc_mem[i] <= '0;
    end else if (alloc_inc) begin
      pc_mem[alloc_idx] <= req_pc;
    end
  end

  // Capture live responses into the slot matching the oldest pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) instr_mem[i] <= '0;
    end else if (rsp_store) begin
      instr_mem[fill_idx] <= rsp_instr;
    end
  end

  // Track responses owed for flushed requests; a flush folds in this cycle's
  // issue (new debt) and response (debt already paid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (flush) begin
      drop_count <= DW'(CW'(drop_count) + CW'(pending) + CW'(req_issue) - CW'(rsp_valid));
    end else if (rsp_drop) begin
      drop_count <= drop_count - DW'(1);
    end
  end

  // Head is read straight from storage; no response bypass.
  assign head.pc    = pc_mem[read_idx];
  assign head.instr = instr_mem[read_idx];
  assign dec_pc     = head.pc;
  assign dec_instr  = head.instr;

  // The cache may still accept a request in a flush cycle, so only the
  // capacity part of req_ready is enforced here.
  a_issue_room : assert property (@(posedge clk) disable iff (!rst_n)
    req_issue |-> room_ok)
    else $error("fetch_response_queue: request issued without room");

  a_no_spurious_rsp : assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> ((pending != '0) || (drop_count != '0)))
    else $error("fetch_response_queue: response with nothing outstanding");

endmodule

// File: tb/tb_fetch_response_queue.sv
// Bench for fetch_response_queue: directed scenarios plus random traffic,
// checked against a queue-based model of outstanding and returned fetches.
module tb_fetch_response_queue;

  localparam int DEPTH = 4;
  localparam int MAX   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_issue = 1'b0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_instr = '0;
  logic        flush = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_pop = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model: PCs awaiting a response, returned pairs awaiting decode, owed drops.
  logic [31:0] m_pend [$];
  logic [31:0] m_rpc  [$];
  logic [31:0] m_rin  [$];
  int          m_drop = 0;

  fetch_response_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_issue (req_issue),
    .req_pc    (req_pc),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .flush     (flush),
    .dec_valid (dec_valid),
    .dec_pc    (dec_pc),
    .dec_instr (dec_instr),
    .dec_pop   (dec_pop)
  );

  always #5 clk = ~clk;

  function automatic bit m_room();
    return ((m_pend.size() + m_rpc.size()) < DEPTH) && ((m_pend.size() + m_drop) < MAX);
  endfunction

  task automatic m_clear();
    m_pend.delete(); m_rpc.delete(); m_rin.delete(); m_drop = 0;
  endtask

  // Apply one cycle's inputs (called just after a rising edge), then wait to mid-cycle.
  task automatic drive(input bit iss, input logic [31:0] pc, input bit rsp,
                       input logic [31:0] ins, input bit fl, input bit pop);
    req_issue = iss; req_pc = pc; rsp_valid = rsp; rsp_instr = ins;
    flush = fl; dec_pop = pop;
    @(negedge clk);
  endtask

  // Clock edge: advance the model with the inputs the DUT just sampled.
  task automatic tick();
    logic [31:0] p;
    @(posedge clk);
    if (flush) begin
      m_drop = m_drop + m_pend.size() + int'(req_issue) - int'(rsp_valid);
      m_pend.delete(); m_rpc.delete(); m_rin.delete();
    end else begin
      if (dec_pop && m_rpc.size() > 0) begin
        void'(m_rpc.pop_front()); void'(m_rin.pop_front());
      end
      if (rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          p = m_pend.pop_front();
          m_rpc.push_back(p); m_rin.push_back(rsp_instr);
        end
      end
      if (req_issue) m_pend.push_back(req_pc);
    end
    #1;
    req_issue = 0; rsp_valid = 0; flush = 0; dec_pop = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; m_clear();
    #12;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", dec_pc); end
    checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", dec_instr); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    drive(1, 32'h100, 0, 0, 0, 0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", req_ready); end
    tick();
    drive(1, 32'h104, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'hA, 0, 0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL basic_nobypass got=%b exp=0", dec_valid); end
    tick();
    drive(0, 0, 1, 32'hB, 0, 0);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0 got=%b exp=1", dec_valid); end
    checks++; if (dec_pc !== 32'h100 || dec_instr !== 32'hA) begin errors++;
      $display("FAIL basic_entry0 got=%h/%h exp=00000100/0000000a", dec_pc, dec_instr); end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (dec_pc !== 32'h100 || dec_instr !== 32'hA) begin errors++;
      $display("FAIL basic_hold0 got=%h/%h exp=00000100/0000000a", dec_pc, dec_instr); end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h104 || dec_instr !== 32'hB) begin errors++;
      $display("FAIL basic_entry1 got=%b %h/%h exp=1 00000104/0000000b", dec_valid, dec_pc, dec_instr); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", dec_valid); end
    tick();
  endtask

  task automatic test_full();
    drive(1, 32'h10, 0, 0, 0, 0); tick();
    drive(1, 32'h14, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h50, 0, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_outstanding got=%b exp=0", req_ready); end
    tick();
    drive(0, 0, 1, 32'h54, 0, 0); tick();
    drive(1, 32'h18, 0, 0, 0, 0); tick();
    drive(1, 32'h1C, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h58, 0, 0); tick();
    drive(0, 0, 1, 32'h5C, 0, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_used4a got=%b exp=0", req_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_used4b got=%b exp=0", req_ready); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h10 + 4*k || dec_instr !== 32'h50 + 4*k) begin errors++;
        $display("FAIL full_drain%0d got=%b %h/%h", k, dec_valid, dec_pc, dec_instr); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (dec_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL full_after got=%b/%b exp=0/1", dec_valid, req_ready); end
    tick();
  endtask

  task automatic test_flush_drop();
    drive(1, 32'h300, 0, 0, 0, 0); tick();
    drive(1, 32'h304, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fdrop_flushready got=%b exp=0", req_ready); end
    tick();
    drive(0, 0, 1, 32'h1111, 0, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fdrop_owed2 got=%b exp=0", req_ready); end
    tick();
    drive(1, 32'h200, 1, 32'h2222, 0, 0);
    checks++; if (req_ready !== 1'b1 || dec_valid !== 1'b0) begin errors++;
      $display("FAIL fdrop_owed1 got=%b/%b exp=1/0", req_ready, dec_valid); end
    tick();
    drive(0, 0, 1, 32'h3333, 0, 0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL fdrop_dropped got=%b exp=0", dec_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== 32'h3333) begin errors++;
      $display("FAIL fdrop_pair got=%b %h/%h exp=1 00000200/00003333", dec_valid, dec_pc, dec_instr); end
    tick();
  endtask

  task automatic test_flush_same_cycle();
    drive(1, 32'h400, 0, 0, 0, 0); tick();
    drive(1, 32'h404, 1, 32'hDEAD, 1, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fsame_ready got=%b exp=0", req_ready); end
    tick();
    drive(1, 32'h408, 0, 0, 0, 0);
    checks++; if (dec_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL fsame_after got=%b/%b exp=0/1", dec_valid, req_ready); end
    tick();
    drive(0, 0, 1, 32'h55, 0, 0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fsame_owed1 got=%b exp=0", req_ready); end
    tick();
    drive(0, 0, 1, 32'h66, 0, 0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL fsame_dropped got=%b exp=0", dec_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h408 || dec_instr !== 32'h66) begin errors++;
      $display("FAIL fsame_pair got=%b %h/%h exp=1 00000408/00000066", dec_valid, dec_pc, dec_instr); end
    tick();
  endtask

  task automatic test_wrap_pop_fill();
    int n_iss = 0, n_pop = 0;
    bit iss, rsp, pop;
    logic [31:0] ins;
    for (int c = 0; c < 15; c++) begin
      iss = (n_iss < 12) && m_room();
      rsp = (m_pend.size() > 0);
      pop = (m_rpc.size() > 0);
      ins = rsp ? (m_pend[0] ^ 32'hFFFF_0000) : 32'h0;
      drive(iss, 32'h1000 + 32'(4*n_iss), rsp, ins, 0, pop);
      if (c >= 2 && c <= 13) begin
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid c=%0d got=%b exp=1", c, dec_valid); end
      end
      if (pop) begin
        checks++; if (dec_pc !== 32'h1000 + 32'(4*n_pop) || dec_instr !== ((32'h1000 + 32'(4*n_pop)) ^ 32'hFFFF_0000)) begin
          errors++; $display("FAIL wrap_order n=%0d got=%h/%h", n_pop, dec_pc, dec_instr); end
        n_pop++;
      end
      if (iss) n_iss++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%b exp=0", dec_valid); end
    tick();
  endtask

  task automatic test_reset_midstream();
    drive(1, 32'h500, 0, 0, 0, 0); tick();
    drive(1, 32'h504, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h1, 0, 0); tick();
    drive(1, 32'h508, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (dec_valid !== 1'b1 || req_ready !== 1'b0) begin errors++;
      $display("FAIL rstmid_pre got=%b/%b exp=1/0", dec_valid, req_ready); end
    #2 rst_n = 0; m_clear();
    #1;
    checks++; if (dec_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL rstmid_async got=%b/%b exp=0/1", dec_valid, req_ready); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    drive(1, 32'h600, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h77, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h600 || dec_instr !== 32'h77) begin errors++;
      $display("FAIL rstmid_nodrop got=%b %h/%h exp=1 00000600/00000077", dec_valid, dec_pc, dec_instr); end
    tick();
  endtask

  task automatic test_random();
    bit iss, rsp, pop, fl, exp_ready, exp_valid;
    logic [31:0] pc, ins;
    for (int c = 0; c < 500; c++) begin
      fl  = ($urandom_range(0, 15) == 0);
      iss = m_room() && ($urandom_range(0, 2) != 0);
      rsp = ((m_pend.size() > 0) || (m_drop > 0)) && ($urandom_range(0, 2) != 0);
      pop = ($urandom_range(0, 1) == 1);
      pc  = $urandom; pc[1:0] = 2'b00;
      ins = $urandom;
      exp_ready = !fl && m_room();
      exp_valid = (m_rpc.size() > 0);
      drive(iss, pc, rsp, ins, fl, pop);
      checks++; if (req_ready !== exp_ready) begin errors++;
        $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      checks++; if (dec_valid !== exp_valid) begin errors++;
        $display("FAIL rand_valid c=%0d got=%b exp=%b", c, dec_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (dec_pc !== m_rpc[0] || dec_instr !== m_rin[0]) begin errors++;
          $display("FAIL rand_head c=%0d got=%h/%h exp=%h/%h", c, dec_pc, dec_instr, m_rpc[0], m_rin[0]); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush_drop();
    test_flush_same_cycle();
    test_wrap_pop_fill();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
